// File: rtl/ser2par_pkg.sv
// Shared defaults and helpers for the ser2par serial-to-parallel collector.
// Widths here match the par2ser transmit side so the two can be paired directly.
package ser2par_pkg;

    localparam int unsigned DEFAULT_DWIDTH  = 16;
    localparam int unsigned DEFAULT_DDWIDTH = 32;

    // Number of serial words that make up one parallel word.
    function automatic int unsigned ratio(input int unsigned dw, input int unsigned ddw);
        return ddw / dw;
    endfunction

endpackage

// File: rtl/ser2par_hs_out_slot.sv
// Single-entry output register with valid flag on a req/ack port.
// A load always wins over a simultaneous ack, so a reload keeps valid asserted.
module ser2par_hs_out_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [0:WIDTH-1] load_data,
    input  logic             ack,
    output logic             valid,
    output logic [0:WIDTH-1] data
);

    logic             valid_q, valid_d;
    logic [0:WIDTH-1] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ser2par.sv
// Collects RATIO serial words into one parallel word; a second group may be
// assembled while the previous one waits in the output slot.
module ser2par
    import ser2par_pkg::*;
#(
    parameter int unsigned DWIDTH  = DEFAULT_DWIDTH,
    parameter int unsigned DDWIDTH = DEFAULT_DDWIDTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic               req_in,
    input  logic               ack_in,
    input  logic [0:DWIDTH-1]  data_in,
    output logic               req_out,
    input  logic               ack_out,
    output logic [0:DDWIDTH-1] data_out
);

    localparam int unsigned   RATIO    = ratio(DWIDTH, DDWIDTH);
    localparam int unsigned   CW       = $clog2(RATIO + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               req_in_q, req_in_d;
    logic [0:DWIDTH-1]  asm_q [RATIO];
    logic               asm_we;
    logic               in_fire, out_fire, slot_free;
    logic               load;
    logic [0:DDWIDTH-1] load_data;

    assign in_fire   = req_in_q & ack_in;
    assign out_fire  = req_out & ack_out;
    assign slot_free = ~req_out | out_fire;

    always_comb begin
        cnt_d  = cnt_q;
        asm_we = 1'b0;
        load   = 1'b0;
        if (in_fire) begin
            if (cnt_q != CNT_LAST) begin
                asm_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
            end else if (slot_free) begin
                load  = 1'b1;
                cnt_d = '0;
            end else begin
                // Slot still occupied: park the full group until it drains.
                asm_we = 1'b1;
                cnt_d  = CNT_FULL;
            end
        end else if (cnt_q == CNT_FULL && slot_free) begin
            load  = 1'b1;
            cnt_d = '0;
        end
        req_in_d = (cnt_d < CNT_FULL);
    end

    // The incoming word bypasses the buffer when it completes a group directly.
    always_comb begin
        load_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (in_fire && cnt_q == CW'(k)) begin
                load_data[k*DWIDTH +: DWIDTH] = data_in;
            end else begin
                load_data[k*DWIDTH +: DWIDTH] = asm_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            req_in_q <= 1'b0;
            for (int k = 0; k < RATIO; k++) begin
                asm_q[k] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            req_in_q <= req_in_d;
            for (int k = 0; k < RATIO; k++) begin
                if (asm_we && cnt_q == CW'(k)) begin
                    asm_q[k] <= data_in;
                end
            end
        end
    end

    assign req_in = req_in_q;

    ser2par_hs_out_slot #(
        .WIDTH(DDWIDTH)
    ) u_out_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_data),
        .ack      (ack_out),
        .valid    (req_out),
        .data     (data_out)
    );

endmodule
